// File: rtl/branch_sequencer.sv
// Registered branch/jump sequencer: owns the fetch PC, resolves branch/jump ops, drives flush and link writes.
// Latency: an accepted op updates pc/flush/link_we/addr_err one cycle later; flush then lasts FLUSH_CYCLES cycles.
// Backpressure: stall_i freezes the PC and blocks acceptance; ops presented while flushing are dropped. Optional BRANCH_STATS_EN adds op counters.
module branch_sequencer #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                INSTR_BYTES  = 4,
  parameter int                FLUSH_CYCLES = 2,
  parameter int                LINK_REG     = 31
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              stall_i,
  input  logic              br_valid_i,
  input  logic [2:0]        br_op_i,
  input  logic              zero_i,
  input  logic              negative_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic [ADDR_W-1:0] reg_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              flush_o,
  output logic              link_we_o,
  output logic [4:0]        link_addr_o,
  output logic [ADDR_W-1:0] link_data_o,
  output logic              addr_err_o,
  output logic [31:0]       taken_cnt_o,
  output logic [31:0]       branch_cnt_o
);

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_BEQ   = 3'b001;
  localparam logic [2:0] OP_BGEZ  = 3'b010;
  localparam logic [2:0] OP_BALRN = 3'b011;
  localparam logic [2:0] OP_J     = 3'b100;
  localparam logic [2:0] OP_JAL   = 3'b101;
  localparam logic [2:0] OP_JPC   = 3'b110;
  localparam logic [2:0] OP_BNE   = 3'b111;

  localparam logic [ADDR_W-1:0] INC        = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
  localparam logic [2:0]        CNT_INIT   = 3'(FLUSH_CYCLES - 1);
  localparam logic [4:0]        LINK_IDX   = 5'(LINK_REG);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              flush_q, flush_d;
  logic              link_we_q, link_we_d;
  logic [ADDR_W-1:0] link_data_q, link_data_d;
  logic              addr_err_q, addr_err_d;

  logic              accept;
  logic              cond;
  logic              is_link;
  logic [ADDR_W-1:0] tgt;
  logic              misalign;
  logic              redirect;

  // Decode the op: taken condition, target source and whether it links.
  always_comb begin
    cond    = 1'b0;
    tgt     = br_target_i;
    is_link = 1'b0;
    case (br_op_i)
      OP_BEQ:   cond = zero_i;
      OP_BNE:   cond = !zero_i;
      OP_BGEZ:  cond = !negative_i;
      OP_BALRN: begin
        cond    = negative_i;
        tgt     = reg_target_i;
        is_link = 1'b1;
      end
      OP_J: begin
        cond = 1'b1;
        tgt  = jump_target_i;
      end
      OP_JAL: begin
        cond    = 1'b1;
        tgt     = jump_target_i;
        is_link = 1'b1;
      end
      OP_JPC: begin
        cond = 1'b1;
        tgt  = reg_target_i;
      end
      default: cond = 1'b0;
    endcase
  end

  assign accept   = br_valid_i && !stall_i && (state_q == RUN) && (br_op_i != OP_NONE);
  assign misalign = |(tgt & ALIGN_MASK);
  // A misaligned taken target degrades to a sequential step plus an error pulse.
  assign redirect = accept && cond && !misalign;

  // Next-state and registered-output logic; flush stays high while the counter drains.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_d     = 1'b0;
    pc_d        = stall_i ? pc_q : pc_q + INC;
    link_we_d   = redirect && is_link;
    addr_err_d  = accept && cond && misalign;
    link_data_d = link_we_d ? br_pc_i + INC : link_data_q;
    case (state_q)
      RUN: begin
        if (redirect) begin
          state_d = FLUSH;
          cnt_d   = CNT_INIT;
          flush_d = 1'b1;
          pc_d    = tgt;
        end
      end
      FLUSH: begin
        // Counter drains even under stall so the flush window has fixed length.
        if (cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          flush_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      pc_q        <= RESET_PC;
      flush_q     <= 1'b0;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign pc_o        = pc_q;
  assign flush_o     = flush_q;
  assign link_we_o   = link_we_q;
  assign link_addr_o = LINK_IDX;
  assign link_data_o = link_data_q;
  assign addr_err_o  = addr_err_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt_q;
  logic [31:0] branch_cnt_q;

  // Saturating counters of accepted ops and of successful redirects.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      taken_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      if (accept && (branch_cnt_q != 32'hFFFF_FFFF)) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (redirect && (taken_cnt_q != 32'hFFFF_FFFF)) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign taken_cnt_o  = taken_cnt_q;
  assign branch_cnt_o = branch_cnt_q;
`else
  assign taken_cnt_o  = 32'd0;
  assign branch_cnt_o = 32'd0;
`endif

endmodule
